fb_1bpp: RTL and testbench
==========================

Name: fb_1bpp

Overview:
- Monochrome 320x200 framebuffer that sits directly upstream of the VGA scan-out timing generator.
- Serves that generator's pixel requests (9-bit x, 8-bit y address in, 1-bit pixel out).
- Accepts drawing commands from the GPU command side through a valid/ready port: set, clear and toggle a pixel, plus a full-screen fill engine.
- Storage is one bit per pixel, address = y*FB_W + x.

Parameters:
- FB_W, 320, framebuffer width in pixels.
- FB_H, 200, framebuffer height in lines.
- AW, 16, memory address width; must satisfy 2^AW >= FB_W*FB_H.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_x  in  9  scan-out pixel column request.
- rd_y  in  8  scan-out pixel row request.
- rd_pix  out  1  pixel value for the previous cycle's (rd_x, rd_y).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  2  00 SET, 01 CLR, 10 FILL, 11 TOGGLE.
- cmd_x  in  9  target column (ignored for FILL).
- cmd_y  in  8  target row (ignored for FILL).
- cmd_color  in  1  fill value (FILL only).
- busy  out  1  high while a FILL or TOGGLE is in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
Read port
- Registered; latency exactly 1 cycle.
- rd_pix(t+1) = mem[rd_y*FB_W + rd_x] sampled at t.
- If rd_x >= FB_W or rd_y >= FB_H, rd_pix(t+1) = 0 and memory is not accessed.
- The read port is independent of the command FSM: never stalls, is never blocked by FILL.
- Same-cycle read and write to one address returns the old value (read-before-write).

Reset
- rd_pix=0, cmd_ready=0 in the reset cycle, then 1; busy=0, done=0, state IDLE, fill counter=0.
- Memory contents are NOT cleared by reset.
- Reset mid-FILL or mid-TOGGLE aborts the operation with no further writes. Pixels already written stay written; no done pulse.

Handshake
- A command is accepted when cmd_valid & cmd_ready at a rising clk edge.
- cmd_ready = (state==IDLE) & ~rst.
- Command fields are sampled only on acceptance.
- Out-of-range coordinates (x >= FB_W or y >= FB_H) for SET/CLR/TOGGLE: the command is accepted, no write occurs, and done pulses the next cycle.

Address arithmetic
- addr = y*FB_W + x, computed at AW bits. The product is never truncated for in-range coordinates.

State machine: IDLE, FILL, TGL_RD, TGL_WR.
- IDLE, accept SET/CLR: write 1/0 at the accept edge. done=1 the next cycle; stay IDLE. Back-to-back SET/CLR sustain 1 command/cycle.
- IDLE, accept FILL: latch cmd_color, counter<=0, go to FILL with busy=1.
- FILL: each cycle write color at address counter, then counter++.
  - The cycle writing address FB_W*FB_H-1 moves to IDLE.
  - done=1 and busy=0 the next cycle.
  - A fill takes exactly FB_W*FB_H = 64000 write cycles.
- IDLE, accept TOGGLE (in range): latch addr, go to TGL_RD (busy=1).
- TGL_RD: read mem[addr] into a holding register, go to TGL_WR.
- TGL_WR: write the inverted value, go to IDLE; done the next cycle.
  - Acceptance to done = 3 cycles.
  - Two consecutive TOGGLEs to one pixel restore its value.
- busy = (state != IDLE).
- done is never asserted together with cmd_ready=0 in IDLE, except during reset.

Test Plan:
- Reset, then FILL color=0 -> busy high for 64000 cycles, a single done pulse, then every in-range rd_x/rd_y read returns 0 one cycle after request.
- SET (0,0), SET (319,199), CLR (319,199) back-to-back with cmd_valid held -> three accepts in three cycles, three done pulses. Reading (0,0) returns 1; reading (319,199) returns 0, checking address 63999.
- TOGGLE (5,7) twice on a cleared screen -> ready low between commands. Read after the first gives 1, after the second gives 0; each done comes 3 cycles after its accept.
- SET (320,0) and SET (0,200) -> accepted, done pulses, no pixel changes (full-screen compare). Read at rd_x=400 returns 0.
- Reset asserted at fill cycle 1000 of FILL color=1 -> busy drops, no done. Addresses 0..999 read 1, address 1000 onward keep prior values, cmd_ready=1 after reset.
- Scan-out read of (10,10) in the same cycle as SET (10,10) on a 0 pixel -> rd_pix=0 next cycle, 1 on a repeat read.

Source files
------------

// File: rtl/fb_1bpp.sv
// fb_1bpp: 320x200 one-bit-per-pixel framebuffer feeding VGA scan-out.
// Ports: clk/rst (sync, active-high); rd_x/rd_y -> rd_pix one cycle later;
// cmd_valid/cmd_ready handshake with cmd_op (SET/CLR/FILL/TOGGLE), cmd_x,
// cmd_y, cmd_color; busy while FILL/TOGGLE runs; done pulses on completion.
module fb_1bpp #(
  parameter int FB_W = 320,
  parameter int FB_H = 200,
  parameter int AW   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] rd_x,
  input  logic [7:0] rd_y,
  output logic       rd_pix,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [8:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic       cmd_color,
  output logic       busy,
  output logic       done
);
  localparam int N = FB_W * FB_H;
  localparam logic [8:0] W9 = 9'(FB_W);
  localparam logic [7:0] H8 = 8'(FB_H);
  localparam logic [AW-1:0] WA = AW'(FB_W);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  typedef enum logic [1:0] {IDLE, FILL, TGL_RD, TGL_WR} state_t;
  state_t state;
  logic mem [N];
  logic [AW-1:0] cnt, taddr, rd_addr, cmd_addr, wa;
  logic fill_color, hold, rd_in, cmd_in, accept, we, wd;
  assign rd_in = (rd_x < W9) && (rd_y < H8);
  assign cmd_in = (cmd_x < W9) && (cmd_y < H8);
  assign rd_addr = AW'(rd_y) * WA + AW'(rd_x);
  assign cmd_addr = AW'(cmd_y) * WA + AW'(cmd_x);
  assign cmd_ready = (state == IDLE) && !rst;
  assign busy = (state != IDLE);
  assign accept = cmd_valid && cmd_ready;
  // Single write port shared by SET/CLR (at accept), FILL and TOGGLE write-back;
  // rst gates the engine writes so a reset aborts without touching memory.
  always_comb begin
    we = (accept && !cmd_op[1] && cmd_in) || (!rst && (state == FILL || state == TGL_WR));
    wa = (state == FILL) ? cnt : (state == TGL_WR) ? taddr : cmd_addr;
    wd = (state == FILL) ? fill_color : (state == TGL_WR) ? ~hold : ~cmd_op[0];
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
      rd_pix <= 1'b0;
    end else begin
      rd_pix <= rd_in ? mem[rd_addr] : 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            if (cmd_op == 2'b10) begin
              state <= FILL;
              cnt <= '0;
              fill_color <= cmd_color;
            end else if (cmd_op == 2'b11 && cmd_in) begin
              state <= TGL_RD;
              taddr <= cmd_addr;
            end else done <= 1'b1;
          end
        FILL: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
        TGL_RD: begin
          hold <= mem[taddr];
          state <= TGL_WR;
        end
        TGL_WR: begin
          state <= IDLE;
          done <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_fb_1bpp.sv
// tb_fb_1bpp: self-checking bench for fb_1bpp with a read scoreboard and command vectors.
module tb_fb_1bpp;
  logic clk, rst, rd_pix, cmd_valid, cmd_ready, cmd_color, busy, done;
  logic [8:0] rd_x, cmd_x;
  logic [7:0] rd_y, cmd_y;
  logic [1:0] cmd_op;
  logic rd_req, rd_chk;
  int n_chk, n_fail;
  bit model [64000];
  typedef struct {int x; int y; bit e;} rexp_t;
  rexp_t exp_q[$];
  typedef struct {logic [1:0] op; int x; int y; int lat; int rx; int ry; bit pix;} vec_t;
  vec_t tbl[10];
  fb_1bpp dut (
    .clk(clk), .rst(rst), .rd_x(rd_x), .rd_y(rd_y), .rd_pix(rd_pix),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction
  always @(posedge clk) rd_chk <= rd_req;
  always @(negedge clk)
    if (rd_chk) begin
      if (exp_q.size() == 0) chk("rd_queue_empty", 1, 0);
      else begin
        rexp_t r;
        r = exp_q.pop_front();
        chk($sformatf("rd_pix(%0d,%0d)", r.x, r.y), int'(rd_pix), int'(r.e));
      end
    end
  function automatic bit in_rng(int x, int y);
    return x < 320 && y < 200;
  endfunction
  task automatic rd(input int x, input int y, input bit e);
    rexp_t r;
    @(negedge clk);
    rd_x = 9'(x);
    rd_y = 8'(y);
    rd_req = 1'b1;
    r.x = x; r.y = y; r.e = e;
    exp_q.push_back(r);
  endtask
  task automatic rd_drain();
    int n;
    @(negedge clk);
    rd_req = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_drain", exp_q.size(), 0);
  endtask
  task automatic model_cmd(input logic [1:0] op, input int x, input int y);
    if (in_rng(x, y))
      model[y*320+x] = (op == 2'b00) ? 1'b1 : (op == 2'b01) ? 1'b0 : ~model[y*320+x];
  endtask
  task automatic do_cmd(input logic [1:0] op, input int x, input int y, input bit c, output int lat);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_x = 9'(x); cmd_y = 8'(y); cmd_color = c; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask
  initial begin
    int lat, bc, dc;
    logic [6:0] rdy_v, done_v;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_x = '0; cmd_y = '0; cmd_color = 1'b0;
    rd_x = '0; rd_y = '0; rd_req = 1'b0;
    tbl[0] = '{2'b00, 0, 0, 1, 0, 0, 1'b1};
    tbl[1] = '{2'b00, 319, 199, 1, 319, 199, 1'b1};
    tbl[2] = '{2'b01, 319, 199, 1, 319, 199, 1'b0};
    tbl[3] = '{2'b00, 320, 0, 1, 0, 1, 1'b0};
    tbl[4] = '{2'b00, 0, 200, 1, 0, 199, 1'b0};
    tbl[5] = '{2'b11, 5, 7, 3, 5, 7, 1'b1};
    tbl[6] = '{2'b11, 5, 7, 3, 5, 7, 1'b0};
    tbl[7] = '{2'b11, 400, 0, 1, 80, 1, 1'b0};
    tbl[8] = '{2'b00, 100, 50, 1, 100, 50, 1'b1};
    tbl[9] = '{2'b01, 0, 0, 1, 0, 0, 1'b0};
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_pix", int'(rd_pix), 0);
    rst = 1'b0;
    #1 chk("post_rst_cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_op = 2'b10; cmd_color = 1'b0; cmd_valid = 1'b1;
    chk("fill_ready", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 64010; i++) begin
      if (busy) bc++;
      if (done) dc++;
      @(negedge clk);
    end
    chk("fill_busy_cycles", bc, 64000);
    chk("fill_done_pulses", dc, 1);
    for (int a = 0; a < 64000; a += 251) rd(a % 320, a / 320, 1'b0);
    rd(319, 199, 1'b0);
    rd_drain();
    for (int i = 0; i < 10; i++) begin
      do_cmd(tbl[i].op, tbl[i].x, tbl[i].y, 1'b0, lat);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      model_cmd(tbl[i].op, tbl[i].x, tbl[i].y);
      rd(tbl[i].rx, tbl[i].ry, tbl[i].pix);
      rd_drain();
    end
    rd(400, 0, 1'b0);
    rd_drain();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_x = 9'd0; cmd_y = 8'd0;
    bc = int'(cmd_ready);
    @(negedge clk);
    dc = int'(done);
    cmd_op = 2'b00; cmd_x = 9'd319; cmd_y = 8'd199;
    bc += int'(cmd_ready);
    @(negedge clk);
    dc += int'(done);
    cmd_op = 2'b01;
    bc += int'(cmd_ready);
    @(negedge clk);
    dc += int'(done);
    cmd_valid = 1'b0;
    chk("b2b_accepts", bc, 3);
    chk("b2b_dones", dc, 3);
    model[0] = 1'b1; model[63999] = 1'b0;
    rd(0, 0, 1'b1);
    rd(319, 199, 1'b0);
    rd_drain();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_x = 9'd5; cmd_y = 8'd7;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      rdy_v[k] = cmd_ready;
      done_v[k] = done;
      if (k == 4) cmd_valid = 1'b0;
    end
    chk("tgl_ready_pattern", int'(rdy_v), int'(7'b1001001));
    chk("tgl_done_pattern", int'(done_v), int'(7'b1001000));
    rd(5, 7, model[7*320+5]);
    rd_drain();
    @(negedge clk);
    rd_x = 9'd10; rd_y = 8'd10; rd_req = 1'b1;
    exp_q.push_back('{10, 10, 1'b0});
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_x = 9'd10; cmd_y = 8'd10;
    chk("rbw_ready", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_q.push_back('{10, 10, 1'b1});
    model[10*320+10] = 1'b1;
    rd_drain();
    @(negedge clk);
    cmd_op = 2'b10; cmd_color = 1'b1; cmd_valid = 1'b1;
    chk("fill1_ready", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    dc = int'(done);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      dc += int'(done);
    end
    rst = 1'b1;
    chk("abort_busy_before", int'(busy), 1);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready_in_rst", int'(cmd_ready), 0);
    dc += int'(done);
    rst = 1'b0;
    #1 chk("abort_ready_after", int'(cmd_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dc += int'(done);
    end
    chk("abort_no_done", dc, 0);
    for (int a = 0; a < 1000; a++) model[a] = 1'b1;
    for (int a = 0; a < 1100; a++) rd(a % 320, a / 320, model[a]);
    for (int a = 1100; a < 64000; a += 199) rd(a % 320, a / 320, model[a]);
    rd(100, 50, model[50*320+100]);
    rd(10, 10, model[10*320+10]);
    rd(319, 199, model[63999]);
    rd_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
